// File: rtl/hub75_capture.sv
// HUB75 receive side: synchronizes the panel shift/latch bus, rebuilds each latched
// row line in a buffer and streams it out to a frame memory write port.
module hub75_capture #(
  parameter int NUM_COLS  = 64,
  parameter int NUM_ROWS  = 32,
  parameter int BIT_DEPTH = 4,
  parameter int COL_W     = 6,
  parameter int ROW_W     = 5,
  parameter int PLANE_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lp_clk,
  input  logic                     latch,
  input  logic                     noe,
  input  logic [ROW_W-1:0]         row,
  input  logic [2:0]               rgb0,
  input  logic [2:0]               rgb1,
  output logic                     wr_en,
  output logic [ROW_W+COL_W-1:0]   wr_addr,
  output logic [PLANE_W-1:0]       wr_plane,
  output logic [5:0]               wr_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err_overrun,
  output logic                     err_len
);

  localparam int IN_W = 3 + ROW_W + 6;
  localparam logic [COL_W:0]     CNT_FULL   = (COL_W+1)'(NUM_COLS);
  localparam logic [COL_W:0]     CNT_ONE    = {{COL_W{1'b0}}, 1'b1};
  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(NUM_COLS - 1);
  localparam logic [COL_W-1:0]   COL_ONE    = {{(COL_W-1){1'b0}}, 1'b1};
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(NUM_ROWS - 1);
  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(BIT_DEPTH - 1);
  localparam logic [PLANE_W-1:0] PLANE_ONE  = {{(PLANE_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {SHIFT = 1'b0, DUMP = 1'b1} state_t;

  logic [IN_W-1:0]    sync1_r;
  logic [IN_W-1:0]    sync2_r;
  logic               lp_prev_r;
  logic               latch_prev_r;
  logic               lp_s;
  logic               latch_s;
  logic               noe_unused;
  logic [ROW_W-1:0]   row_s;
  logic [5:0]         pix_s;
  logic               lp_rise_s;
  logic               latch_rise_s;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [COL_W:0]     cnt_r;
  logic [COL_W:0]     cnt_nxt_s;
  logic [COL_W-1:0]   col_r;
  logic [ROW_W-1:0]   row_q;
  logic [PLANE_W-1:0] plane_q;
  logic               prev_valid_r;
  logic               done_pend_r;
  logic               store_s;
  logic               latch_go_s;
  logic               overrun_s;
  logic               last_col_s;
  logic [5:0]         line_buf [NUM_COLS];

  // noe travels the same path as everything else but drives nothing
  assign {lp_s, latch_s, noe_unused, row_s, pix_s} = sync2_r;
  assign lp_rise_s    = lp_s & ~lp_prev_r;
  assign latch_rise_s = latch_s & ~latch_prev_r;

  // two-flop synchronizer for the whole bus plus strobe edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r      <= {IN_W{1'b0}};
      sync2_r      <= {IN_W{1'b0}};
      lp_prev_r    <= 1'b0;
      latch_prev_r <= 1'b0;
    end else begin
      sync1_r      <= {lp_clk, latch, noe, row, rgb0, rgb1};
      sync2_r      <= sync1_r;
      lp_prev_r    <= lp_s;
      latch_prev_r <= latch_s;
    end
  end

  // next-state and per-cycle control decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    store_s     = 1'b0;
    latch_go_s  = 1'b0;
    overrun_s   = 1'b0;
    last_col_s  = 1'b0;
    case (state_r)
      SHIFT: begin
        // the pixel is stored before the latch looks at the count
        if (lp_rise_s && (cnt_r < CNT_FULL)) begin
          store_s   = 1'b1;
          cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
          store_s   = 1'b0;
        end
        if (latch_rise_s) begin
          latch_go_s  = 1'b1;
          state_nxt_s = DUMP;
        end else begin
          latch_go_s  = 1'b0;
        end
      end
      DUMP: begin
        overrun_s = lp_rise_s | latch_rise_s;
        if (col_r == COL_LAST) begin
          last_col_s  = 1'b1;
          state_nxt_s = SHIFT;
        end else begin
          last_col_s  = 1'b0;
        end
      end
      default: begin
        state_nxt_s = SHIFT;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SHIFT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // line buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (store_s) begin
      line_buf[cnt_r[COL_W-1:0]] <= pix_s;
    end
  end

  // shift count, row/plane tracking, dump column and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= {(COL_W+1){1'b0}};
      col_r        <= {COL_W{1'b0}};
      row_q        <= {ROW_W{1'b0}};
      plane_q      <= {PLANE_W{1'b0}};
      prev_valid_r <= 1'b0;
      err_len      <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      cnt_r <= latch_go_s ? {(COL_W+1){1'b0}} : cnt_nxt_s;
      if (latch_go_s) begin
        row_q        <= row_s;
        prev_valid_r <= 1'b1;
        if (prev_valid_r && (row_s == row_q)) begin
          plane_q <= (plane_q == PLANE_LAST) ? {PLANE_W{1'b0}} : plane_q + PLANE_ONE;
        end else begin
          plane_q <= {PLANE_W{1'b0}};
        end
        if (cnt_nxt_s != CNT_FULL) begin
          err_len <= 1'b1;
        end
      end
      col_r <= (state_r == DUMP) ? col_r + COL_ONE : {COL_W{1'b0}};
      if (overrun_s) begin
        err_overrun <= 1'b1;
      end
    end
  end

  // registered write port; frame_done trails the final write of a frame by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en       <= 1'b0;
      busy        <= 1'b0;
      wr_addr     <= {(ROW_W+COL_W){1'b0}};
      wr_plane    <= {PLANE_W{1'b0}};
      wr_data     <= 6'd0;
      done_pend_r <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      wr_en       <= (state_r == DUMP);
      busy        <= (state_r == DUMP);
      if (state_r == DUMP) begin
        wr_addr  <= {row_q, col_r};
        wr_plane <= plane_q;
        wr_data  <= line_buf[col_r];
      end
      done_pend_r <= last_col_s && (row_q == ROW_LAST) && (plane_q == PLANE_LAST);
      frame_done  <= done_pend_r;
    end
  end

endmodule

// File: doc/hub75_capture.md
Name: hub75_capture

Overview:
- Receive end of the panel shift/latch interface; the counterpart of our HUB75 panel driver.
- Samples LP_CLK/LATCH/NOE/ROW/RGB0/RGB1 with the system clock, rebuilds each latched row line, and streams it into a frame memory write port.
- Used on-chip for loopback self-test of the panel driver.
- Also used as the front end of a panel-chaining emulator.

Parameters:
- NUM_COLS, 64, pixels shifted per row line.
- NUM_ROWS, 32, physical scan rows (row select range 0..NUM_ROWS-1).
- BIT_DEPTH, 4, bit planes latched per row before the row advances.
- COL_W, 6, column address width.
- ROW_W, 5, row address width.
- PLANE_W, 2, plane index width.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- lp_clk  in  1  panel shift clock; data is valid on its rising edge.
- latch  in  1  row latch strobe, active-high.
- noe  in  1  output enable (active-low); monitored only.
- row  in  ROW_W  row select.
- rgb0  in  3  upper-half pixel bits.
- rgb1  in  3  lower-half pixel bits.
- wr_en  out  1  frame memory write strobe.
- wr_addr  out  ROW_W+COL_W  {row, col}.
- wr_plane  out  PLANE_W  bit plane of the write.
- wr_data  out  6  {rgb0, rgb1}.
- busy  out  1  high while a line dump is in progress.
- frame_done  out  1  one-cycle pulse after the last row/plane of a frame is written.
- err_overrun  out  1  sticky: an lp_clk edge or latch arrived during a dump.
- err_len  out  1  sticky: a latch arrived with shift count != NUM_COLS.

Behaviour:
- Input sampling: all panel inputs pass through a 2-flop synchronizer, then one edge-detect register. Every input sees identical delay, so data and strobes stay aligned.
- Minimum input timing: lp_clk and latch are each high ≥2 clk and low ≥2 clk.
- Shift capture (state SHIFT): each synchronized lp_clk rising edge stores {rgb0,rgb1} into line buffer entry shift_cnt, then increments shift_cnt.
  - The k-th shifted pixel (0-based) is column k.
  - When shift_cnt ≥ NUM_COLS, data is dropped and shift_cnt saturates at NUM_COLS.
- Latch handling: a synchronized latch rising edge in SHIFT captures row into row_q.
  - Plane: if row equals the previous latched row, plane_q increments modulo BIT_DEPTH; otherwise plane_q = 0. The first latch after reset gives plane 0.
  - If shift_cnt != NUM_COLS, set err_len. The dump still proceeds; unshifted entries hold stale buffer contents.
  - Clear shift_cnt and go to DUMP on the next cycle.
- DUMP: wr_en is high for exactly NUM_COLS consecutive cycles.
  - col runs 0..NUM_COLS-1; wr_addr = {row_q, col}, wr_plane = plane_q, wr_data = buffer[col].
  - busy is high for the same cycles.
  - After the last write, return to SHIFT.
- frame_done pulses the cycle after the last write when row_q = NUM_ROWS-1 and plane_q = BIT_DEPTH-1.
- Latency: from raw latch rise to first wr_en is 4 clk (2 sync + edge + state entry).
- Simultaneous lp_clk edge and latch edge in SHIFT: store the pixel first, then evaluate the length check on the updated count.
- Any lp_clk edge or latch edge during DUMP: ignored (no buffer or count change) and err_overrun is set.
- noe has no functional effect.
- Reset (also mid-dump):
  - State SHIFT; wr_en, busy, frame_done = 0.
  - wr_addr, wr_plane, wr_data = 0.
  - shift_cnt, plane_q = 0; previous row = invalid.
  - err_overrun, err_len = 0.
  - Synchronizer and edge registers cleared; line buffer contents are don't-care.
  - An aborted dump is not resumed.
- Error flags clear only on rst.

Test Plan:
- 64 lp_clk pulses with {rgb0,rgb1} = col[5:0], then latch with row = 5 → 64 writes, addr 0x140..0x17F, wr_data = col, plane 0, err_len = 0, busy high 64 cycles.
- Same row 5 latched four times, then row 6 → planes 0,1,2,3, then 0 for row 6.
- Full frame of 32 rows × 4 planes → frame_done pulses exactly once, one cycle after write to addr 0x7FF, plane 3.
- 60 pulses then latch → err_len = 1, 64 writes still issued; 70 pulses then latch → columns 0..63 hold the first 64 pixels, err_len = 1.
- lp_clk edge injected during DUMP → err_overrun = 1, dump data unchanged, next line captured correctly.
- rst asserted at dump write 10 → wr_en = 0 next cycle, all flags clear, the following full line is captured with plane 0.
